// File: rtl/fxp_to_bcd.sv
// -----------------------------------------------------------------------------
// fxp_to_bcd
// Converts an unsigned Q16.8 fixed-point value into BCD for display.
//
// The integer part (16 bits) is converted with a serial double-dabble loop,
// one bit per clock. The fraction is then expanded into decimal digits by
// repeated multiply-by-ten, one digit per clock. The fraction is truncated.
// Total latency from the accepting edge to done is 16 + FRAC_DIGITS edges.
//
// An upstream error presented with a start request skips the conversion.
// One edge after acceptance, done and error rise and every output nibble
// shows the blank code 4'hF.
//
// Handshake: i_start is accepted on an edge where the block is in IDLE or DONE
// and no error report is pending. i_val and i_err are only looked at on that
// edge. done stays high, with o_int_bcd/o_frac_bcd/error stable, until the next
// accepted start or reset. i_start while busy is ignored.
//
// Ports
//   CLK          in   system clock, rising edge
//   RST          in   synchronous active-high reset, wins over i_start
//   i_start      in   conversion request
//   i_val        in   M-bit unsigned Q16.8 value
//   i_err        in   upstream error flag
//   o_int_bcd    out  five BCD digits of the integer part, MSD in [19:16]
//   o_frac_bcd   out  FRAC_DIGITS BCD fraction digits, first digit on top
//   busy         out  high while converting (INT or FRAC)
//   done         out  result valid, held
//   error        out  result reflects an upstream error
//   o_dbg_state  out  current FSM state (debug)
// -----------------------------------------------------------------------------
module fxp_to_bcd #(
    parameter int M           = 24,
    parameter int I_FRAC      = 8,
    parameter int FRAC_DIGITS = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_start,
    input  logic [M-1:0]               i_val,
    input  logic                       i_err,
    output logic [19:0]                o_int_bcd,
    output logic [4*FRAC_DIGITS-1:0]   o_frac_bcd,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 o_dbg_state
);

    localparam int INT_BITS = M - I_FRAC;
    localparam int FW       = 4 * FRAC_DIGITS;
    localparam logic [4:0] INT_LAST  = 5'(INT_BITS - 1);
    localparam logic [4:0] FRAC_LAST = 5'(FRAC_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INT  = 2'd1,
        S_FRAC = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   err_pend_q, err_pend_d;
    logic [INT_BITS-1:0]    bin_q, bin_d;
    logic [19:0]            bcd_q, bcd_d;
    logic [I_FRAC-1:0]      frac_q, frac_d;
    logic [FW-1:0]          fdig_q, fdig_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [19:0]            int_out_q, int_out_d;
    logic [FW-1:0]          frac_out_q, frac_out_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    // Double-dabble adjust: every nibble >= 5 gets +3 before the shift.
    logic [19:0]            bcd_adj;
    // Fraction times ten, built from shifts; 12 bits hold 255*10.
    logic [I_FRAC+3:0]      frac_x10;
    logic [3:0]             frac_digit;
    logic [FW-1:0]          fdig_next;
    logic                   can_accept;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        frac_x10   = ({4'b0000, frac_q} << 3) + ({4'b0000, frac_q} << 1);
        frac_digit = frac_x10[I_FRAC+3:I_FRAC];
        fdig_next  = {fdig_q[FW-5:0], frac_digit};
    end

    // A pending error report blocks acceptance for its one cycle.
    assign can_accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && !err_pend_q;

    always_comb begin
        state_d    = state_q;
        err_pend_d = err_pend_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        frac_d     = frac_q;
        fdig_d     = fdig_q;
        cnt_d      = cnt_q;
        int_out_d  = int_out_q;
        frac_out_d = frac_out_q;
        done_d     = done_q;
        error_d    = error_q;

        if (err_pend_q) begin
            err_pend_d = 1'b0;
            done_d     = 1'b1;
            error_d    = 1'b1;
            int_out_d  = '1;
            frac_out_d = '1;
            state_d    = S_DONE;
        end else if (can_accept && i_start) begin
            done_d  = 1'b0;
            error_d = 1'b0;
            if (i_err) begin
                err_pend_d = 1'b1;
            end else begin
                bin_d   = i_val[M-1:I_FRAC];
                frac_d  = i_val[I_FRAC-1:0];
                bcd_d   = '0;
                fdig_d  = '0;
                cnt_d   = '0;
                state_d = S_INT;
            end
        end else begin
            case (state_q)
                S_INT: begin
                    bcd_d = {bcd_adj[18:0], bin_q[INT_BITS-1]};
                    bin_d = {bin_q[INT_BITS-2:0], 1'b0};
                    if (cnt_q == INT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FRAC;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_FRAC: begin
                    fdig_d = fdig_next;
                    frac_d = frac_x10[I_FRAC-1:0];
                    if (cnt_q == FRAC_LAST) begin
                        cnt_d      = '0;
                        int_out_d  = bcd_q;
                        frac_out_d = fdig_next;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            err_pend_q <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            frac_q     <= '0;
            fdig_q     <= '0;
            cnt_q      <= '0;
            int_out_q  <= '0;
            frac_out_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_pend_q <= err_pend_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            frac_q     <= frac_d;
            fdig_q     <= fdig_d;
            cnt_q      <= cnt_d;
            int_out_q  <= int_out_d;
            frac_out_q <= frac_out_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign o_int_bcd   = int_out_q;
    assign o_frac_bcd  = frac_out_q;
    assign busy        = (state_q == S_INT) || (state_q == S_FRAC);
    assign done        = done_q;
    assign error       = error_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fxp_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_fxp_to_bcd
// Directed bench for fxp_to_bcd: reset, latency/busy window, fraction digits,
// full-scale truncation, error path, abort by reset, back-to-back starts.
// -----------------------------------------------------------------------------
module tb_fxp_to_bcd;

    logic        CLK;
    logic        RST;
    logic        i_start;
    logic [23:0] i_val;
    logic        i_err;
    logic [19:0] o_int_bcd;
    logic [11:0] o_frac_bcd;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    fxp_to_bcd #(.M(24), .I_FRAC(8), .FRAC_DIGITS(3)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_start     (i_start),
        .i_val       (i_val),
        .i_err       (i_err),
        .o_int_bcd   (o_int_bcd),
        .o_frac_bcd  (o_frac_bcd),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drivers: inputs change on the falling edge; the following rising edge is
    // the sampling edge N. Returns at the falling edge after N with i_start low
    // and i_val/i_err scrambled (they must be ignored from here on).
    task automatic pulse_start(input logic [23:0] val, input logic err);
        @(negedge CLK);
        i_start = 1'b1;
        i_val   = val;
        i_err   = err;
        @(negedge CLK);
        i_start = 1'b0;
        i_val   = 24'($urandom);
        i_err   = 1'($urandom_range(0, 1));
    endtask

    // Counts falling edges until done is seen, bounded at 50.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        i_start = 1'b1;
        i_val = 24'h123456;
        i_err = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({o_int_bcd, o_frac_bcd, busy, done, error} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got int=%h frac=%h busy=%b done=%b err=%b, expected all 0",
                     o_int_bcd, o_frac_bcd, busy, done, error);
        end
        checks++;
        if (o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", o_dbg_state);
        end
        i_start = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if ({o_int_bcd, o_frac_bcd, busy, done, error} !== 35'd0) begin
            errors++;
            $display("FAIL idle_hold: got int=%h frac=%h busy=%b done=%b err=%b, expected all 0",
                     o_int_bcd, o_frac_bcd, busy, done, error);
        end
    endtask

    task automatic test_basic();
        int busy_lo;
        int cyc;
        pulse_start(24'h000100, 1'b0);
        // falling edges after N .. N+18 must show busy=1, done=0
        busy_lo = 0;
        for (int k = 0; k < 19; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_lo++;
            if (k < 18) @(negedge CLK);
        end
        checks++;
        if (busy_lo != 0) begin
            errors++;
            $display("FAIL busy_window: got %0d bad cycles expected 0", busy_lo);
        end
        cyc = 18;
        while (!done && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (cyc != 19) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 19", cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: got %b expected 0", busy);
        end
        checks++;
        if (o_int_bcd !== 20'h00001 || o_frac_bcd !== 12'h000) begin
            errors++;
            $display("FAIL basic_value: got %h.%h expected 00001.000", o_int_bcd, o_frac_bcd);
        end
    endtask

    task automatic test_fraction();
        int cyc;
        pulse_start(24'h0002B7, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 19 || o_int_bcd !== 20'h00002 || o_frac_bcd !== 12'h714) begin
            errors++;
            $display("FAIL frac_2B7: got %h.%h after %0d expected 00002.714 after 19",
                     o_int_bcd, o_frac_bcd, cyc);
        end
        pulse_start(24'h00005E, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 19 || o_int_bcd !== 20'h00000 || o_frac_bcd !== 12'h367) begin
            errors++;
            $display("FAIL frac_05E: got %h.%h after %0d expected 00000.367 after 19",
                     o_int_bcd, o_frac_bcd, cyc);
        end
        pulse_start(24'h303980, 1'b0);
        wait_done(cyc);
        checks++;
        if (o_int_bcd !== 20'h12345 || o_frac_bcd !== 12'h500) begin
            errors++;
            $display("FAIL frac_12345: got %h.%h expected 12345.500", o_int_bcd, o_frac_bcd);
        end
    endtask

    task automatic test_max();
        int cyc;
        pulse_start(24'hFFFFFF, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 19 || o_int_bcd !== 20'h65535 || o_frac_bcd !== 12'h996) begin
            errors++;
            $display("FAIL max_value: got %h.%h after %0d expected 65535.996 after 19",
                     o_int_bcd, o_frac_bcd, cyc);
        end
        // outputs hold in DONE while i_start stays low
        repeat (5) @(negedge CLK);
        checks++;
        if (done !== 1'b1 || o_int_bcd !== 20'h65535 || o_frac_bcd !== 12'h996) begin
            errors++;
            $display("FAIL done_hold: got done=%b %h.%h expected 1 65535.996",
                     done, o_int_bcd, o_frac_bcd);
        end
    endtask

    task automatic test_error();
        int cyc;
        pulse_start(24'h000100, 1'b1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_accept: got done=%b busy=%b expected 0 0", done, busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 1 || error !== 1'b1) begin
            errors++;
            $display("FAIL err_latency: got cyc=%0d error=%b expected 1 1", cyc, error);
        end
        checks++;
        if (o_int_bcd !== 20'hFFFFF || o_frac_bcd !== 12'hFFF) begin
            errors++;
            $display("FAIL err_blank: got %h.%h expected FFFFF.FFF", o_int_bcd, o_frac_bcd);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (error !== 1'b1 || done !== 1'b1 || o_int_bcd !== 20'hFFFFF) begin
            errors++;
            $display("FAIL err_hold: got err=%b done=%b int=%h expected 1 1 FFFFF",
                     error, done, o_int_bcd);
        end
        pulse_start(24'h000100, 1'b0);
        checks++;
        if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err=%b done=%b busy=%b expected 0 0 1", error, done, busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 19 || error !== 1'b0 || o_int_bcd !== 20'h00001 || o_frac_bcd !== 12'h000) begin
            errors++;
            $display("FAIL err_recover: got %h.%h err=%b after %0d expected 00001.000 err=0 after 19",
                     o_int_bcd, o_frac_bcd, error, cyc);
        end
    endtask

    task automatic test_abort();
        int cyc;
        int done_seen;
        pulse_start(24'h000100, 1'b0);          // edge N
        repeat (4) @(negedge CLK);              // after N+4
        i_start = 1'b1;                         // sampled at N+5, busy -> ignored
        i_val   = 24'h000200;
        @(negedge CLK);
        i_start = 1'b0;
        repeat (3) @(negedge CLK);              // after N+8
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_midconv: got busy=%b done=%b expected 1 0", busy, done);
        end
        @(negedge CLK);                         // after N+9
        RST = 1'b1;
        @(negedge CLK);                         // after N+10
        RST = 1'b0;
        checks++;
        if ({o_int_bcd, o_frac_bcd, busy, done, error} !== 35'd0 || o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_reset: got int=%h frac=%h busy=%b done=%b err=%b st=%0d expected all 0",
                     o_int_bcd, o_frac_bcd, busy, done, error, o_dbg_state);
        end
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
        end
        pulse_start(24'h000200, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 19 || o_int_bcd !== 20'h00002 || o_frac_bcd !== 12'h000) begin
            errors++;
            $display("FAIL abort_restart: got %h.%h after %0d expected 00002.000 after 19",
                     o_int_bcd, o_frac_bcd, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // done is high from the previous test; hold i_start through two runs
        @(negedge CLK);
        i_start = 1'b1;
        i_val   = 24'h00C864;
        i_err   = 1'b0;
        @(negedge CLK);                         // after accepting edge
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drop1: got done=%b busy=%b expected 0 1", done, busy);
        end
        i_val = 24'h303980;                     // changes mid-conversion, must not leak in
        i_err = 1'b1;
        @(negedge CLK);
        i_err = 1'b0;
        cyc = 1;
        while (!done && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (cyc != 19 || o_int_bcd !== 20'h00200 || o_frac_bcd !== 12'h390 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got %h.%h err=%b after %0d expected 00200.390 err=0 after 19",
                     o_int_bcd, o_frac_bcd, error, cyc);
        end
        @(negedge CLK);                         // held i_start accepted again
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drop2: got done=%b busy=%b expected 0 1", done, busy);
        end
        i_start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc != 19 || o_int_bcd !== 20'h12345 || o_frac_bcd !== 12'h500) begin
            errors++;
            $display("FAIL b2b_second: got %h.%h after %0d expected 12345.500 after 19",
                     o_int_bcd, o_frac_bcd, cyc);
        end
    endtask

    initial begin
        RST     = 1'b1;
        i_start = 1'b0;
        i_val   = '0;
        i_err   = 1'b0;
        test_reset();
        test_basic();
        test_fraction();
        test_max();
        test_error();
        test_abort();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
